// File: rtl/fc_layer_seq.sv
// Fully connected layer sequencer: walks neurons x input chunks, drives memory addresses, accumulates ALU results.
// Optional macro FC_RELU_EN fuses a ReLU after the 16-bit saturation of each neuron result.
module fc_layer_seq #(
    parameter int N_IN_CHUNKS = 4,
    parameter int N_OUT       = 10,
    parameter int AW          = 8,
    parameter int ACC_W       = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] act_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] b_addr,
    output logic          bias_en,
    input  logic [16:0]   alu_result,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_EMIT, S_DONE} state_t;

    localparam logic [AW-1:0]           CHUNKS      = AW'(N_IN_CHUNKS);
    localparam logic [AW-1:0]           LAST_CHUNK  = AW'(N_IN_CHUNKS - 1);
    localparam logic [AW-1:0]           LAST_NEURON = AW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX     = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN     = ACC_W'(-32768);

    state_t                  state_q, state_d;
    logic [AW-1:0]           neuron_q, neuron_d;
    logic [AW-1:0]           chunk_q, chunk_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] alu_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [15:0]             out_q, out_d;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'h7fff;
        else if (v < SAT_MIN) return 16'h8000;
        else                  return v[15:0];
    endfunction

    function automatic logic [15:0] neuron_out(input logic signed [ACC_W-1:0] v);
        logic [15:0] s;
        s = sat16(v);
`ifdef FC_RELU_EN
        if (s[15]) s = 16'h0000;
`endif
        return s;
    endfunction

    assign alu_ext = ACC_W'($signed(alu_result));
    assign acc_sum = acc_q + alu_ext;

    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        chunk_d  = chunk_q;
        acc_d    = acc_q;
        out_d    = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    neuron_d = '0;
                    chunk_d  = '0;
                    acc_d    = '0;
                end
            end
            S_FETCH: state_d = S_ACC;
            S_ACC: begin
                acc_d = acc_sum;
                if (chunk_q < LAST_CHUNK) begin
                    chunk_d = chunk_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    out_d   = neuron_out(acc_sum);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // Everything holds while downstream stalls; only a handshake advances.
                if (out_ready) begin
                    if (neuron_q < LAST_NEURON) begin
                        neuron_d = neuron_q + 1'b1;
                        chunk_d  = '0;
                        acc_d    = '0;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            neuron_q <= '0;
            chunk_q  <= '0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            chunk_q  <= chunk_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
        end
    end

    // Counters only move on entry to FETCH, so addresses hold their last value elsewhere.
    assign act_addr  = chunk_q;
    assign w_addr    = neuron_q * CHUNKS + chunk_q;
    assign b_addr    = neuron_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_rd    = (state_q == S_FETCH);
    assign bias_en   = (state_q == S_ACC) && (chunk_q == '0);
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = out_q;

endmodule
